top_wb: RTL
===========

Name: top_wb

Overview:
- Write-back stage of the 5-stage MIPS pipeline.
- Its registered write port drives the register file write inputs of the instruction-decode stage: write enable, destination register and write data.
- Holds the MEM/WB pipeline register and selects between the ALU result and load data.
- Aligns and sign/zero-extends sub-word loads, and supports stall (debug step mode) and flush.

Parameters:
- CANT_REGISTROS, 32, number of architectural registers; address width is clogb2(CANT_REGISTROS-1).
- CANT_BITS_REGISTROS, 32, data width of the register file.
- CANT_BITS_LOAD_TYPE, 3, width of the load-type code.
- CANT_BITS_CONTADOR, 32, width of the retired-instruction counter (optional feature).

Ports:
- i_clock  in  1  system clock; all state updates on the rising edge.
- i_soft_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  pipeline advance; 0 holds the register (debug step/stall).
- i_flush  in  1  squashes the instruction being captured.
- i_valid  in  1  MEM stage holds a real instruction.
- i_RegWrite  in  1  instruction writes a register.
- i_MemtoReg  in  1  1 selects load data, 0 selects the ALU result.
- i_reg_rd  in  clogb2(CANT_REGISTROS-1)  destination register.
- i_alu_result  in  CANT_BITS_REGISTROS  ALU result from MEM.
- i_mem_data  in  CANT_BITS_REGISTROS  raw data-memory word.
- i_load_type  in  CANT_BITS_LOAD_TYPE  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; other codes are treated as LW.
- i_byte_offset  in  2  address bits [1:0] of the load.
- o_control_write_reg  out  1  register file write enable.
- o_reg_write  out  clogb2(CANT_REGISTROS-1)  register file write address.
- o_data_write  out  CANT_BITS_REGISTROS  register file write data.
- o_valid  out  1  WB stage holds a valid instruction.
- o_retired_count  out  CANT_BITS_CONTADOR  retired-instruction count (present only with the optional feature).

Behaviour:
- Reset (i_soft_reset=0, asynchronous): all registered state clears to 0, so every output reads 0, including o_retired_count.
- Capture condition, on a rising edge with i_enable=1:
  - valid_q <= i_valid & ~i_flush;
  - rd_q, regwrite_q, memtoreg_q <= corresponding inputs;
  - data_q <= i_MemtoReg ? aligned(i_mem_data) : i_alu_result.
- Stall: with i_enable=0 all registers hold their values, except that i_flush=1 clears valid_q. Flush takes priority over stall.
- Latency: one cycle from MEM inputs to the write port.
- Outputs are driven directly from registers (no combinational paths from inputs).
- o_control_write_reg = valid_q & regwrite_q & (rd_q != 0). Writes to register 0 are always suppressed.
- o_reg_write = rd_q; o_data_write = data_q; o_valid = valid_q.
- Alignment is little-endian:
  - byte = i_mem_data[8*off +: 8];
  - half = i_mem_data[16*off[1] +: 16], with off[0] ignored (misaligned halfword is not trapped);
  - LB/LH sign-extend to CANT_BITS_REGISTROS; LBU/LHU zero-extend;
  - LW ignores the offset.
- Alignment applies only when i_MemtoReg=1.
- A flushed or invalid instruction never asserts o_control_write_reg, whatever i_RegWrite is.
- Reset asserted mid-stall: cleared immediately; the pipeline resumes from empty after deassertion.

Optional Feature:
- Macro: WB_RETIRE_COUNTER_EN.
- Defined: a CANT_BITS_CONTADOR-bit counter increments by 1 on each capture edge where i_enable=1, i_valid=1 and i_flush=0.
  - Counts retired instructions, whether or not they write a register.
  - Wraps from all-ones to 0.
  - Held during stall; cleared by reset.
  - Exposed on o_retired_count for the debug unit.
- Undefined: no counter and no o_retired_count port; everything else is identical.

Decomposition:
- Shared package: load-type codes (LOAD_LW=3'b000, LOAD_LH=3'b001, LOAD_LHU=3'b010, LOAD_LB=3'b011, LOAD_LBU=3'b100) and CANT_BITS_LOAD_TYPE. The MEM-stage control uses the same codes.
- One combinational sub-module, load_aligner, with inputs i_mem_data, i_load_type and i_byte_offset and output o_data_aligned.
- top_wb holds the pipeline register, the write-enable logic and the optional counter.

Test Plan:
- ALU write-back: i_valid=1, i_RegWrite=1, i_MemtoReg=0, rd=5, alu=0x0000_1234 -> next cycle we=1, o_reg_write=5, o_data_write=0x0000_1234.
- Load alignment: mem=0x80FF_7F01.
  - LB off=2 -> 0xFFFF_FFFF; LBU off=3 -> 0x0000_0080; LH off=0 -> 0x0000_7F01.
  - LHU off=2 -> 0x0000_80FF; LH off=2 -> 0xFFFF_80FF; LW off=1 -> 0x80FF_7F01.
- r0 suppression: rd=0, i_RegWrite=1, alu=0xDEAD_BEEF -> o_control_write_reg=0, o_valid=1.
- Stall/flush:
  - capture rd=7, then hold i_enable=0 for 3 cycles while inputs change -> outputs unchanged;
  - assert i_flush during the stall -> next edge o_valid=0, we=0;
  - i_flush with i_enable=1 and i_valid=1 -> no write.
- Reset: drive i_soft_reset=0 mid-cycle while we=1 -> outputs 0 immediately (before the next edge); after release, the first capture behaves normally.
- WB_RETIRE_COUNTER_EN:
  - 10 valid captures with 2 flushed and 3 stall cycles interleaved -> count=8;
  - preload the counter to all-ones via a force, then one retirement -> wraps to 0.

Source files
------------

// File: rtl/top_wb_pkg.sv
// Shared definitions for the MIPS write-back stage.
// Load-type codes are also used by the MEM-stage control.
package top_wb_pkg;

  localparam int LOAD_TYPE_W = 3;

  typedef enum logic [LOAD_TYPE_W-1:0] {
    LOAD_LW  = 3'b000,
    LOAD_LH  = 3'b001,
    LOAD_LHU = 3'b010,
    LOAD_LB  = 3'b011,
    LOAD_LBU = 3'b100
  } load_type_e;

  // Number of bits needed to represent 'value'; never less than 1.
  function automatic int clogb2(input int value);
    int v;
    int bits;
    v    = value;
    bits = 0;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    if (bits == 0) bits = 1;
    return bits;
  endfunction

endpackage

// File: rtl/top_wb_load_aligner.sv
// load_aligner: picks the addressed byte/halfword out of a little-endian
// memory word and sign- or zero-extends it. Purely combinational.
// The data width must be at least 32 bits; only the low word is laned.
module load_aligner
  import top_wb_pkg::*;
#(
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_LOAD_TYPE = LOAD_TYPE_W
) (
  input  logic [CANT_BITS_REGISTROS-1:0] i_mem_data,
  input  logic [CANT_BITS_LOAD_TYPE-1:0] i_load_type,
  input  logic [1:0]                     i_byte_offset,
  output logic [CANT_BITS_REGISTROS-1:0] o_data_aligned
);

  logic [7:0]  byte_lane [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = i_mem_data[8*gi +: 8];
    end
  endgenerate

  assign byte_sel = byte_lane[i_byte_offset];
  // offset bit 0 is ignored for halfwords: misaligned halves are not trapped
  assign half_sel = i_byte_offset[1] ? i_mem_data[31:16] : i_mem_data[15:0];

  // Extend the selected lane according to the load type; unknown codes act as LW
  always_comb begin
    o_data_aligned = i_mem_data;
    case (i_load_type)
      LOAD_LB:  o_data_aligned = {{(CANT_BITS_REGISTROS-8){byte_sel[7]}}, byte_sel};
      LOAD_LBU: o_data_aligned = {{(CANT_BITS_REGISTROS-8){1'b0}}, byte_sel};
      LOAD_LH:  o_data_aligned = {{(CANT_BITS_REGISTROS-16){half_sel[15]}}, half_sel};
      LOAD_LHU: o_data_aligned = {{(CANT_BITS_REGISTROS-16){1'b0}}, half_sel};
      default:  o_data_aligned = i_mem_data;
    endcase
  end

endmodule

// File: rtl/top_wb.sv
// top_wb: write-back stage of the 5-stage MIPS pipeline.
// Holds the MEM/WB register, selects ALU result vs aligned load data and
// drives the register-file write port one cycle after MEM.
// Optional feature macro: WB_RETIRE_COUNTER_EN adds a retired-instruction
// counter on o_retired_count.
module top_wb
  import top_wb_pkg::*;
#(
  parameter int CANT_REGISTROS      = 32,
  parameter int CANT_BITS_REGISTROS = 32,
  parameter int CANT_BITS_LOAD_TYPE = LOAD_TYPE_W,
  parameter int CANT_BITS_CONTADOR  = 32,
  localparam int ADDR_W             = clogb2(CANT_REGISTROS-1)
) (
  input  logic                           i_clock,
  input  logic                           i_soft_reset,
  input  logic                           i_enable,
  input  logic                           i_flush,
  input  logic                           i_valid,
  input  logic                           i_RegWrite,
  input  logic                           i_MemtoReg,
  input  logic [ADDR_W-1:0]              i_reg_rd,
  input  logic [CANT_BITS_REGISTROS-1:0] i_alu_result,
  input  logic [CANT_BITS_REGISTROS-1:0] i_mem_data,
  input  logic [CANT_BITS_LOAD_TYPE-1:0] i_load_type,
  input  logic [1:0]                     i_byte_offset,
  output logic                           o_control_write_reg,
  output logic [ADDR_W-1:0]              o_reg_write,
  output logic [CANT_BITS_REGISTROS-1:0] o_data_write,
  output logic                           o_valid
`ifdef WB_RETIRE_COUNTER_EN
  ,
  output logic [CANT_BITS_CONTADOR-1:0]  o_retired_count
`endif
);

  logic                           valid_reg;
  logic                           regwrite_reg;
  logic                           memtoreg_reg;
  logic [ADDR_W-1:0]              rd_reg;
  logic [CANT_BITS_REGISTROS-1:0] data_reg;
  logic [CANT_BITS_REGISTROS-1:0] aligned_data;
  logic [CANT_BITS_REGISTROS-1:0] data_next;

  load_aligner #(
    .CANT_BITS_REGISTROS (CANT_BITS_REGISTROS),
    .CANT_BITS_LOAD_TYPE (CANT_BITS_LOAD_TYPE)
  ) u_load_aligner (
    .i_mem_data     (i_mem_data),
    .i_load_type    (i_load_type),
    .i_byte_offset  (i_byte_offset),
    .o_data_aligned (aligned_data)
  );

  // Alignment result is only used for loads; otherwise pass the ALU result
  assign data_next = i_MemtoReg ? aligned_data : i_alu_result;

  // MEM/WB register: capture on enable, hold on stall, flush always squashes valid
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      valid_reg    <= 1'b0;
      regwrite_reg <= 1'b0;
      memtoreg_reg <= 1'b0;
      rd_reg       <= '0;
      data_reg     <= '0;
    end else if (i_enable) begin
      valid_reg    <= i_valid & ~i_flush;
      regwrite_reg <= i_RegWrite;
      memtoreg_reg <= i_MemtoReg;
      rd_reg       <= i_reg_rd;
      data_reg     <= data_next;
    end else if (i_flush) begin
      valid_reg    <= 1'b0;
    end
  end

  // Writes to r0 are dropped here so the register file never sees them
  assign o_control_write_reg = valid_reg & regwrite_reg & (rd_reg != '0);
  assign o_reg_write         = rd_reg;
  assign o_data_write        = data_reg;
  assign o_valid             = valid_reg;

`ifdef WB_RETIRE_COUNTER_EN
  logic [CANT_BITS_CONTADOR-1:0] retired_reg;

  // Count every instruction that retires into WB, writing or not; wraps freely
  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      retired_reg <= '0;
    end else if (i_enable && i_valid && !i_flush) begin
      retired_reg <= retired_reg + CANT_BITS_CONTADOR'(1);
    end
  end

  assign o_retired_count = retired_reg;
`endif

endmodule
